// File: rtl/spi_cfg_seq_if.sv
// Bus bundle between the config sequencer and its environment: init table,
// runtime update port, SPI writer handshake and status flags.
interface spi_cfg_seq_if #(
    parameter int unsigned AW = 4
);
    logic          start;
    logic [AW-1:0] tbl_idx;
    logic [14:0]   tbl_data;
    logic          upd_valid;
    logic [14:0]   upd_data;
    logic          upd_ready;
    logic          spi_req;
    logic [14:0]   spi_data;
    logic          spi_done;
    logic          busy;
    logic          init_done;
    logic          err;

    modport master (
        output start, tbl_data, upd_valid, upd_data, spi_done,
        input  tbl_idx, upd_ready, spi_req, spi_data, busy, init_done, err
    );

    modport slave (
        input  start, tbl_data, upd_valid, upd_data, spi_done,
        output tbl_idx, upd_ready, spi_req, spi_data, busy, init_done, err
    );
endinterface

// File: rtl/spi_cfg_seq.sv
// Sequencer/arbiter in front of the 15-bit SPI writer: walks the init table on
// start, then accepts single runtime writes; flags busy, init completion, timeout.
module spi_cfg_seq #(
    parameter int unsigned NUM_REGS    = 11,
    parameter int unsigned AW          = 4,
    parameter int unsigned REQ_CYC     = 2,
    parameter int unsigned GAP_CYC     = 64,
    parameter int unsigned TIMEOUT_CYC = 128
) (
    input logic         clk,
    input logic         rst_n,
    spi_cfg_seq_if.slave bus
);

    localparam int unsigned RW = $clog2(REQ_CYC + 1);
    localparam int unsigned GW = $clog2(GAP_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [RW-1:0] REQ_LAST = RW'(REQ_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_REGS - 1);

    if (NUM_REGS < 1 || NUM_REGS > (1 << AW)) begin : g_bad_num_regs
        $error("spi_cfg_seq: NUM_REGS out of range for AW");
    end
    if (REQ_CYC < 2 || GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_timing
        $error("spi_cfg_seq: REQ_CYC must be >= 2, GAP_CYC and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_GAP
    } state_t;

    typedef enum logic {
        M_INIT,
        M_UPD
    } mode_t;

    state_t        state, state_nx;
    mode_t         mode, mode_nx;
    logic [AW-1:0] idx, idx_nx;
    logic [RW-1:0] req_cnt, req_cnt_nx;
    logic [GW-1:0] gap_cnt, gap_cnt_nx;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nx;
    logic          req_q, req_nx;
    logic [14:0]   data_q, data_nx;
    logic          done_q, done_nx;
    logic          err_q, err_nx;
    logic          upd_ready;

    // start has priority over a pending update in the same IDLE cycle
    assign upd_ready     = (state == S_IDLE) & done_q & ~bus.start;
    assign bus.upd_ready = upd_ready;
    assign bus.tbl_idx   = idx;
    assign bus.spi_req   = req_q;
    assign bus.spi_data  = data_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.init_done = done_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mode    <= M_INIT;
            idx     <= '0;
            req_cnt <= '0;
            gap_cnt <= '0;
            tmo_cnt <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            mode    <= mode_nx;
            idx     <= idx_nx;
            req_cnt <= req_cnt_nx;
            gap_cnt <= gap_cnt_nx;
            tmo_cnt <= tmo_cnt_nx;
            req_q   <= req_nx;
            data_q  <= data_nx;
            done_q  <= done_nx;
            err_q   <= err_nx;
        end
    end

    // Counters default to zero so each state starts its own count on entry
    always_comb begin
        state_nx   = state;
        mode_nx    = mode;
        idx_nx     = idx;
        req_cnt_nx = '0;
        gap_cnt_nx = '0;
        tmo_cnt_nx = '0;
        req_nx     = req_q;
        data_nx    = data_q;
        done_nx    = done_q;
        err_nx     = err_q;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    idx_nx   = '0;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                    mode_nx  = M_INIT;
                    state_nx = S_LOAD;
                end else if (bus.upd_valid && upd_ready) begin
                    data_nx  = bus.upd_data;
                    req_nx   = 1'b1;
                    mode_nx  = M_UPD;
                    state_nx = S_REQ;
                end
            end
            S_LOAD: begin
                data_nx  = bus.tbl_data;
                req_nx   = 1'b1;
                state_nx = S_REQ;
            end
            S_REQ: begin
                if (req_cnt == REQ_LAST) begin
                    req_nx   = 1'b0;
                    state_nx = S_WAIT;
                end else begin
                    req_cnt_nx = req_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.spi_done) begin
                    state_nx = S_GAP;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (mode == M_UPD) begin
                        state_nx = S_IDLE;
                    end else if (idx == IDX_LAST) begin
                        done_nx  = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        state_nx = S_LOAD;
                    end
                end else begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_cfg_seq.sv
// Directed bench for spi_cfg_seq: SPI writer model plus a scoreboard of expected
// words, checked when each request rises.
module tb_spi_cfg_seq;

    localparam int unsigned DONE_LAT = 34;
    localparam int unsigned REQ_CYC  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_cfg_seq_if #(.AW(4)) bus ();

    spi_cfg_seq #(.NUM_REGS(3), .AW(4), .REQ_CYC(2), .GAP_CYC(64), .TIMEOUT_CYC(128)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [14:0] tbl_mem [0:15];
    assign bus.tbl_data = tbl_mem[bus.tbl_idx];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_req    = 0;
    int          req_len  = 0;
    int          since_rise = 0;
    int          done_cyc = 0;
    bit          armed    = 1'b0;
    bit          has_done = 1'b0;
    bit          hang     = 1'b0;
    logic        prev_req = 1'b0;
    logic [14:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SPI writer model and scoreboard consumer, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.spi_done = 1'b0;
            armed        = 1'b0;
            has_done     = 1'b0;
            prev_req     = 1'b0;
        end else begin
            bus.spi_done = 1'b0;
            if (armed) begin
                since_rise++;
                if (since_rise == DONE_LAT) begin
                    armed = 1'b0;
                    if (!hang) begin
                        bus.spi_done = 1'b1;
                        done_cyc     = cyc;
                        has_done     = 1'b1;
                    end
                end
            end
            if (bus.spi_req && !prev_req) begin
                n_req++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    chk("spi_data", 32'(bus.spi_data), 32'(exp_q.pop_front()));
                end
                if (has_done) chk("gap_ge_64", 32'((cyc - done_cyc - 1) >= 64), 32'd1);
                has_done   = 1'b0;
                req_len    = 1;
                armed      = 1'b1;
                since_rise = 0;
            end else if (bus.spi_req) begin
                req_len++;
            end else if (prev_req) begin
                chk("req_len", 32'(req_len), 32'(REQ_CYC));
            end
            prev_req = bus.spi_req;
        end
    end

    task automatic wait_init_done(input string tag);
        int n = 0;
        while (bus.init_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.init_done), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic push_table(input int count);
        for (int i = 0; i < count; i++) exp_q.push_back(tbl_mem[i]);
    endtask

    initial begin
        int n;
        int req_snap;
        for (int i = 0; i < 16; i++) tbl_mem[i] = '0;
        tbl_mem[0] = 15'h1234;
        tbl_mem[1] = 15'h0A5F;
        tbl_mem[2] = 15'h7FFF;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.upd_valid = 1'b0;
        bus.upd_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_spi_req", 32'(bus.spi_req), 32'd0);
        chk("rst_spi_data", 32'(bus.spi_data), 32'd0);
        chk("rst_upd_ready", 32'(bus.upd_ready), 32'd0);
        chk("rst_tbl_idx", 32'(bus.tbl_idx), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: init sequence of three words, with 6: start/update while busy ignored
        push_table(3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("t1_load_busy", 32'(bus.busy), 32'd1);
        chk("t1_load_req", 32'(bus.spi_req), 32'd0);
        chk("t1_load_idx", 32'(bus.tbl_idx), 32'd0);
        @(negedge clk);
        chk("t1_req_latency", 32'(bus.spi_req), 32'd1);
        repeat (5) @(negedge clk);
        bus.start     = 1'b1;
        bus.upd_valid = 1'b1;
        bus.upd_data  = 15'h3333;
        #1;
        chk("t6_upd_ready_busy", 32'(bus.upd_ready), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_upd_ready_hold", 32'(bus.upd_ready), 32'd0);
        chk("t6_idx_unchanged", 32'(bus.tbl_idx), 32'd0);
        bus.upd_valid = 1'b0;
        wait_init_done("t1_init_done");
        chk("t1_busy", 32'(bus.busy), 32'd0);
        chk("t1_err", 32'(bus.err), 32'd0);
        chk("t1_req_count", 32'(n_req), 32'd3);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: runtime update after init
        @(negedge clk);
        exp_q.push_back(15'h5A5A);
        bus.upd_valid = 1'b1;
        bus.upd_data  = 15'h5A5A;
        #1;
        chk("t3_upd_ready", 32'(bus.upd_ready), 32'd1);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        chk("t3_req", 32'(bus.spi_req), 32'd1);
        n = 1;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk("t3_busy_cycles", 32'(n), 32'd99);
        chk("t3_init_done_kept", 32'(bus.init_done), 32'd1);
        chk("t3_req_count", 32'(n_req), 32'd4);

        // 4: start and update together; update waits for the rerun to finish
        @(negedge clk);
        push_table(3);
        exp_q.push_back(15'h1111);
        bus.start     = 1'b1;
        bus.upd_valid = 1'b1;
        bus.upd_data  = 15'h1111;
        #1;
        chk("t4_upd_ready_start", 32'(bus.upd_ready), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("t4_init_done_cleared", 32'(bus.init_done), 32'd0);
        wait_init_done("t4_init_done");
        chk("t4_upd_ready_first_idle", 32'(bus.upd_ready), 32'd1);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        chk("t4_upd_req", 32'(bus.spi_req), 32'd1);
        wait_idle("t4_idle");
        chk("t4_req_count", 32'(n_req), 32'd8);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: writer never answers -> timeout, then a fresh start recovers
        @(negedge clk);
        hang = 1'b1;
        push_table(1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.spi_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bus.spi_req !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bus.err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t2_err_latency", 32'(n), 32'd128);
        chk("t2_busy", 32'(bus.busy), 32'd0);
        chk("t2_init_done", 32'(bus.init_done), 32'd0);
        chk("t2_spi_data_held", 32'(bus.spi_data), 32'h1234);
        repeat (3) @(negedge clk);
        chk("t2_err_sticky", 32'(bus.err), 32'd1);
        hang = 1'b0;
        push_table(3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("t2_err_cleared", 32'(bus.err), 32'd0);
        chk("t2_idx_restart", 32'(bus.tbl_idx), 32'd0);
        wait_init_done("t2_rerun_done");
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: asynchronous reset during WAIT of the second word
        @(negedge clk);
        push_table(2);
        req_snap = n_req;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (n_req != req_snap + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bus.spi_req !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_spi_req", 32'(bus.spi_req), 32'd0);
        chk("t5_spi_data", 32'(bus.spi_data), 32'd0);
        chk("t5_tbl_idx", 32'(bus.tbl_idx), 32'd1 - 32'd1);
        chk("t5_init_done", 32'(bus.init_done), 32'd0);
        chk("t5_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_snap = n_req;
        repeat (200) @(negedge clk);
        chk("t5_no_req_after_reset", 32'(n_req - req_snap), 32'd0);
        chk("t5_idle_after_reset", 32'(bus.busy), 32'd0);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
